// File: rtl/fpu_issue_ctrl.sv
// Issue controller for a multi-cycle FPU: accepts one op at a time, holds the
// FPU inputs stable for EXEC_CYCLES cycles, captures the result and returns it
// with the requester tag, accumulating sticky exception flags.
module fpu_issue_ctrl #(
  parameter int unsigned EXEC_CYCLES = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_funct7,
  input  logic [2:0]  req_rm,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [3:0]  req_tag,
  input  logic [2:0]  csr_frm,
  output logic [31:0] fpu_fp1,
  output logic [31:0] fpu_fp2,
  output logic [2:0]  fpu_frm,
  output logic [6:0]  fpu_funct7,
  input  logic [31:0] fpu_out,
  input  logic [4:0]  fpu_flags,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_flags,
  output logic [3:0]  resp_tag,
  output logic        resp_illegal,
  output logic [4:0]  fflags,
  input  logic        fflags_clr,
  output logic        busy
);

  localparam int unsigned CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);
  localparam logic [6:0] F7_ADD  = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0000100;
  localparam logic [6:0] F7_MUL  = 7'b0001000;
  localparam logic [6:0] F7_IDLE = 7'b1111111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    funct7_q, funct7_d;
  logic [2:0]    rm_q, rm_d;
  logic [31:0]   rs1_q, rs1_d, rs2_q, rs2_d;
  logic [3:0]    tag_q, tag_d;
  logic [31:0]   result_q, result_d;
  logic [4:0]    flags_q, flags_d;
  logic          illegal_q, illegal_d;
  logic [4:0]    fflags_q, fflags_d;

  logic [2:0] rm_res;
  logic       op_illegal;
  logic       accept;
  logic       resp_hs;

  assign rm_res     = (req_rm == 3'b111) ? csr_frm : req_rm;
  assign op_illegal = !(req_funct7 == F7_ADD || req_funct7 == F7_SUB || req_funct7 == F7_MUL)
                      || (rm_res == 3'b101) || (rm_res == 3'b110) || (rm_res == 3'b111);
  assign accept     = (state_q == IDLE) && req_valid;
  assign resp_hs    = (state_q == RESP) && resp_ready;

  // Next-state and datapath-register update logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct7_d  = funct7_q;
    rm_d      = rm_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    tag_d     = tag_q;
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    fflags_d  = fflags_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          funct7_d = req_funct7;
          rm_d     = rm_res;
          rs1_d    = req_rs1;
          rs2_d    = req_rs2;
          tag_d    = req_tag;
          cnt_d    = '0;
          if (op_illegal) begin
            // Illegal ops skip the FPU entirely and answer with a zero payload.
            illegal_d = 1'b1;
            result_d  = '0;
            flags_d   = '0;
            state_d   = RESP;
          end else begin
            illegal_d = 1'b0;
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == CNT_LAST) begin
          result_d = fpu_out;
          flags_d  = fpu_flags;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over prior state but the flags of a legal response still land.
    if (fflags_clr) begin
      fflags_d = '0;
    end
    if (resp_hs && !illegal_q) begin
      fflags_d = (fflags_clr ? 5'b0 : fflags_q) | flags_q;
    end
  end

  // State and payload registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      funct7_q  <= '0;
      rm_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      tag_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      fflags_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct7_q  <= funct7_d;
      rm_q      <= rm_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      tag_q     <= tag_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
      fflags_q  <= fflags_d;
    end
  end

  // Outputs: FPU inputs are only driven while executing, idle-coded otherwise
  always_comb begin
    req_ready    = (state_q == IDLE);
    busy         = (state_q != IDLE);
    resp_valid   = (state_q == RESP);
    resp_result  = result_q;
    resp_flags   = flags_q;
    resp_tag     = tag_q;
    resp_illegal = illegal_q;
    fflags       = fflags_q;
    fpu_funct7   = F7_IDLE;
    fpu_fp1      = '0;
    fpu_fp2      = '0;
    fpu_frm      = '0;
    if (state_q == EXEC) begin
      fpu_funct7 = funct7_q;
      fpu_fp1    = rs1_q;
      fpu_fp2    = rs2_q;
      fpu_frm    = rm_q;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl with a stub FPU that only presents a
// valid result in the final execute cycle.
module tb_fpu_issue_ctrl;

  localparam int EC = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_funct7;
  logic [2:0]  req_rm;
  logic [31:0] req_rs1, req_rs2;
  logic [3:0]  req_tag;
  logic [2:0]  csr_frm;
  logic [31:0] fpu_fp1, fpu_fp2;
  logic [2:0]  fpu_frm;
  logic [6:0]  fpu_funct7;
  logic [31:0] fpu_out;
  logic [4:0]  fpu_flags;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic [4:0]  resp_flags;
  logic [3:0]  resp_tag;
  logic        resp_illegal;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flg;
    logic [3:0]  tag;
    logic        ill;
  } resp_t;

  resp_t      sb[$];
  logic [4:0] exp_fflags;
  int         exec_cnt = 0;

  fpu_issue_ctrl #(.EXEC_CYCLES(EC)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct7(req_funct7), .req_rm(req_rm),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .csr_frm(csr_frm),
    .fpu_fp1(fpu_fp1), .fpu_fp2(fpu_fp2), .fpu_frm(fpu_frm), .fpu_funct7(fpu_funct7),
    .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .resp_tag(resp_tag), .resp_illegal(resp_illegal),
    .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stub FPU: known IEEE cases, otherwise a recognisable pattern with NX set.
  function automatic logic [36:0] fpu_model(input logic [6:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f == 7'b0000000 && a == 32'h3F800000 && b == 32'h40000000) return {5'b00000, 32'h40400000};
    if (f == 7'b0001000 && a == 32'h40000000 && b == 32'h40400000) return {5'b00000, 32'h40C00000};
    if (f == 7'b0000000 && a == 32'h7F800000 && b == 32'hFF800000) return {5'b10000, 32'h7FC00000};
    if (f == 7'b0000100 && a == 32'h40400000 && b == 32'h3F800000) return {5'b00000, 32'h40000000};
    return {5'b00001, a ^ b};
  endfunction

  // Count consecutive cycles the FPU has been driven; result valid only in the last one.
  always @(posedge clk) begin
    if (fpu_funct7 != 7'h7F) exec_cnt <= exec_cnt + 1;
    else                     exec_cnt <= 0;
  end

  always_comb begin
    {fpu_flags, fpu_out} = {5'b11111, 32'hBADBAD00};
    if (fpu_funct7 != 7'h7F && exec_cnt == EC - 1)
      {fpu_flags, fpu_out} = fpu_model(fpu_funct7, fpu_fp1, fpu_fp2);
  end

  function automatic resp_t expect_of(input logic [6:0] f, input logic [2:0] rm, input logic [2:0] frm,
                                      input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    logic [2:0]  r;
    logic [36:0] m;
    r = (rm == 3'b111) ? frm : rm;
    if (!(f == 7'h00 || f == 7'h04 || f == 7'h08) || r == 3'b101 || r == 3'b110 || r == 3'b111)
      return {32'h0, 5'h0, t, 1'b1};
    m = fpu_model(f, a, b);
    return {m[31:0], m[36:32], t, 1'b0};
  endfunction

  // Drive one request at a negedge while IDLE; it is accepted on the next posedge.
  task automatic issue(input logic [6:0] f, input logic [2:0] rm, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] t);
    req_funct7 = f; req_rm = rm; req_rs1 = a; req_rs2 = b; req_tag = t;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for the response, monitor FPU inputs, stall, then complete the handshake.
  task automatic collect(input logic [2:0] efrm, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input bit clr_hs, input bit noise,
                         output int lat, output resp_t got, output bit saw_active,
                         output bit exec_ok, output bit hold_ok, output bit idle_ok);
    lat = 1; saw_active = 0; exec_ok = 1; hold_ok = 1; idle_ok = 1;
    if (noise) begin
      req_valid = 1'b1; req_tag = 4'hF; req_funct7 = 7'h00; req_rs1 = 32'h1; req_rm = 3'b000;
    end
    while (!resp_valid && lat < 60) begin
      if (fpu_funct7 !== 7'h7F) begin
        saw_active = 1;
        if (fpu_fp1 !== a || fpu_fp2 !== b || fpu_frm !== efrm) exec_ok = 0;
      end else if (fpu_fp1 !== 0 || fpu_fp2 !== 0 || fpu_frm !== 0) begin
        idle_ok = 0;
      end
      if (req_ready !== 1'b0 || busy !== 1'b1) hold_ok = 0;
      @(negedge clk);
      lat++;
    end
    got = {resp_result, resp_flags, resp_tag, resp_illegal};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if ({resp_result, resp_flags, resp_tag, resp_illegal} !== got || resp_valid !== 1'b1 ||
          req_ready !== 1'b0) hold_ok = 0;
      if (fpu_funct7 !== 7'h7F || fpu_fp1 !== 0 || fpu_fp2 !== 0 || fpu_frm !== 0) idle_ok = 0;
    end
    resp_ready = 1'b1; fflags_clr = clr_hs;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0; fflags_clr = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    vectors++; if ({resp_result, resp_flags, resp_tag, resp_illegal} !== 42'h0) begin miscompares++;
      $display("FAIL reset_payload got=%h exp=0", {resp_result, resp_flags, resp_tag, resp_illegal}); end
    vectors++; if (fflags !== 5'h0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_fflags_busy got=%h/%b exp=0/0", fflags, busy); end
    vectors++; if (fpu_funct7 !== 7'h7F || fpu_fp1 !== 0 || fpu_fp2 !== 0 || fpu_frm !== 0) begin miscompares++;
      $display("FAIL reset_fpu_idle got=%h %h %h %h exp=7f 0 0 0", fpu_funct7, fpu_fp1, fpu_fp2, fpu_frm); end
    nrst = 1'b1;
    exp_fflags = 5'h0;
    @(negedge clk);
  endtask

  task automatic run_legal(input string nm, input logic [6:0] f, input logic [2:0] rm, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] t, input int stall, input bit clr_hs, input bit noise);
    int lat; resp_t got, exp; bit saw, eok, hok, iok;
    logic [2:0] efrm;
    efrm = (rm == 3'b111) ? csr_frm : rm;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL %s_ready_before got=%b exp=1", nm, req_ready); end
    sb.push_back(expect_of(f, rm, csr_frm, a, b, t));
    issue(f, rm, a, b, t);
    collect(efrm, a, b, stall, clr_hs, noise, lat, got, saw, eok, hok, iok);
    exp = sb.pop_front();
    exp_fflags = (clr_hs ? 5'h0 : exp_fflags) | exp.flg;
    vectors++; if (lat !== EC + 1) begin miscompares++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, EC + 1); end
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL %s_payload got=%h exp=%h", nm, got, exp); end
    vectors++; if (!(saw && eok)) begin miscompares++; $display("FAIL %s_exec_inputs got=%b%b exp=11", nm, saw, eok); end
    vectors++; if (!(hok && iok)) begin miscompares++; $display("FAIL %s_hold_idle got=%b%b exp=11", nm, hok, iok); end
    vectors++; if (fflags !== exp_fflags) begin miscompares++; $display("FAIL %s_fflags got=%b exp=%b", nm, fflags, exp_fflags); end
    vectors++; if (busy !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL %s_back_idle got=%b%b exp=01", nm, busy, req_ready); end
  endtask

  task automatic test_add();
    csr_frm = 3'b000;
    run_legal("add", 7'h00, 3'b000, 32'h3F800000, 32'h40000000, 4'd3, 0, 0, 0);
  endtask

  task automatic test_mul_dynrm();
    csr_frm = 3'b000;
    run_legal("mul_dyn0", 7'h08, 3'b111, 32'h40000000, 32'h40400000, 4'd5, 0, 0, 0);
    csr_frm = 3'b010;
    run_legal("mul_dyn2", 7'h08, 3'b111, 32'h40000000, 32'h40400000, 4'd6, 1, 0, 0);
    csr_frm = 3'b000;
  endtask

  task automatic test_inf_flags();
    run_legal("inf_add", 7'h00, 3'b001, 32'h7F800000, 32'hFF800000, 4'd7, 0, 0, 0);
    vectors++; if (fflags !== 5'b10000) begin miscompares++; $display("FAIL inf_fflags got=%b exp=10000", fflags); end
  endtask

  task automatic test_illegal();
    logic [6:0] f7s[2];
    logic [2:0] rms[2];
    f7s[0] = 7'b0101010; rms[0] = 3'b000;
    f7s[1] = 7'b0000000; rms[1] = 3'b101;
    for (int k = 0; k < 2; k++) begin
      int lat; resp_t got, exp; bit saw, eok, hok, iok;
      sb.push_back(expect_of(f7s[k], rms[k], csr_frm, 32'h3F800000, 32'h40000000, 4'(9 + k)));
      issue(f7s[k], rms[k], 32'h3F800000, 32'h40000000, 4'(9 + k));
      collect(3'b000, 32'h3F800000, 32'h40000000, 2, 0, 0, lat, got, saw, eok, hok, iok);
      exp = sb.pop_front();
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL illegal%0d_latency got=%0d exp=1", k, lat); end
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL illegal%0d_payload got=%h exp=%h", k, got, exp); end
      vectors++; if (saw || !iok) begin miscompares++; $display("FAIL illegal%0d_fpu_driven got=%b%b exp=01", k, saw, iok); end
      vectors++; if (fflags !== exp_fflags) begin miscompares++; $display("FAIL illegal%0d_fflags got=%b exp=%b", k, fflags, exp_fflags); end
    end
  endtask

  task automatic test_backpressure();
    run_legal("sub_stall", 7'h04, 3'b000, 32'h40400000, 32'h3F800000, 4'd12, 3, 0, 1);
  endtask

  task automatic test_fflags_clr();
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    exp_fflags = 5'h0;
    vectors++; if (fflags !== 5'h0) begin miscompares++; $display("FAIL clr_alone got=%b exp=00000", fflags); end
    run_legal("nx_acc", 7'h00, 3'b000, 32'h12345678, 32'h0F0F0F0F, 4'd1, 0, 0, 0);
    run_legal("inf_acc", 7'h00, 3'b000, 32'h7F800000, 32'hFF800000, 4'd2, 0, 0, 0);
    vectors++; if (fflags !== 5'b10001) begin miscompares++; $display("FAIL fflags_accum got=%b exp=10001", fflags); end
    run_legal("clr_hs", 7'h04, 3'b010, 32'hAAAA0000, 32'h00005555, 4'd4, 0, 1, 0);
    vectors++; if (fflags !== 5'b00001) begin miscompares++; $display("FAIL clr_with_hs got=%b exp=00001", fflags); end
  endtask

  task automatic test_reset_midexec();
    bit seen;
    issue(7'h00, 3'b000, 32'h3F800000, 32'h40000000, 4'd8);
    repeat (2) @(negedge clk);
    nrst = 1'b0; fflags_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    exp_fflags = 5'h0;
    vectors++; if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin miscompares++;
      $display("FAIL midreset_state got=%b%b%b exp=100", req_ready, busy, resp_valid); end
    vectors++; if ({resp_result, resp_flags, resp_tag, resp_illegal} !== 42'h0 || fflags !== 5'h0) begin miscompares++;
      $display("FAIL midreset_payload got=%h/%b exp=0/0", {resp_result, resp_flags, resp_tag, resp_illegal}, fflags); end
    vectors++; if (fpu_funct7 !== 7'h7F || fpu_fp1 !== 0 || fpu_fp2 !== 0 || fpu_frm !== 0) begin miscompares++;
      $display("FAIL midreset_fpu got=%h %h %h %h exp=7f 0 0 0", fpu_funct7, fpu_fp1, fpu_fp2, fpu_frm); end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    vectors++; if (seen) begin miscompares++; $display("FAIL midreset_no_resp got=1 exp=0"); end
  endtask

  initial begin
    nrst = 1'b0; req_valid = 1'b0; req_funct7 = 7'h0; req_rm = 3'b0; req_rs1 = '0; req_rs2 = '0;
    req_tag = '0; csr_frm = 3'b0; resp_ready = 1'b0; fflags_clr = 1'b0; exp_fflags = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_mul_dynrm();
    test_inf_flags();
    test_illegal();
    test_backpressure();
    test_fflags_clr();
    test_reset_midexec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameter: EXEC_CYCLES, default 4, number of cycles each operation holds the FPU inputs stable before capture.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 nrst  input  1  reset; synchronous, active-low, one clock, sampled on the rising edge of clk.
REQ-004 req_valid  input  1  requester has an operation.
REQ-005 req_ready  output  1  controller accepts an operation this cycle.
REQ-006 req_funct7  input  7  opcode: ADD 7'b0000000, SUB 7'b0000100, MUL 7'b0001000.
REQ-007 req_rm  input  3  rounding mode; 3'b111 means dynamic (use csr_frm).
REQ-008 req_rs1, req_rs2  input  32 each  IEEE-754 single operands.
REQ-009 req_tag  input  4  requester tag, returned unchanged.
REQ-010 csr_frm  input  3  dynamic rounding mode.
REQ-011 fpu_fp1, fpu_fp2  output  32 each  operands to the FPU datapath.
REQ-012 fpu_frm  output  3  resolved rounding mode to the FPU.
REQ-013 fpu_funct7  output  7  opcode to the FPU; 7'b1111111 means idle.
REQ-014 fpu_out  input  32  FPU result.
REQ-015 fpu_flags  input  5  FPU flags {NV,DZ,OF,UF,NX}.
REQ-016 resp_valid  output  1  response available.
REQ-017 resp_ready  input  1  consumer accepts the response.
REQ-018 resp_result, resp_flags, resp_tag, resp_illegal  output  32/5/4/1  response payload.
REQ-019 fflags  output  5  sticky accumulated exception flags.
REQ-020 fflags_clr  input  1  clears fflags.
REQ-021 busy  output  1  state is not IDLE.

Function
REQ-022 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-023 req_ready SHALL be 1 exactly in IDLE, with no combinational dependence on req_valid.
REQ-024 On req_valid & req_ready, the controller SHALL latch funct7, the resolved rm (req_rm, or csr_frm when req_rm==3'b111), rs1, rs2 and tag.
REQ-025 The op is illegal if funct7 is not ADD, SUB or MUL, or if the resolved rm is 3'b101, 3'b110 or 3'b111.
REQ-026 Legal op: IDLE->EXEC with a cycle counter of 0; the counter SHALL increment each EXEC cycle.
REQ-027 During EXEC, fpu_fp1, fpu_fp2, fpu_frm and fpu_funct7 SHALL be driven from the latched values and held constant, because the FPU reads its live inputs in its later stages.
REQ-028 In the EXEC cycle where the counter is EXEC_CYCLES-1, resp_result<=fpu_out and resp_flags<=fpu_flags SHALL be captured; the FSM then goes to RESP.
REQ-029 Legal-op latency: resp_valid SHALL rise EXEC_CYCLES+1 cycles after the accept edge (5 at default).
REQ-030 Illegal op: IDLE->RESP directly with resp_illegal=1, resp_result=0 and resp_flags=0; resp_valid SHALL be 1 on the cycle after accept, and the FPU is not driven.
REQ-031 Outside EXEC, fpu_funct7 SHALL be 7'b1111111, and fpu_fp1, fpu_fp2 and fpu_frm SHALL be 0.
REQ-032 resp_valid SHALL be 1 exactly in RESP, with the payload held stable until resp_valid & resp_ready.
REQ-033 On the response handshake the FSM SHALL go RESP->IDLE; no new request is accepted in that same cycle.
REQ-034 On a legal-op response handshake, fflags SHALL become fflags | resp_flags.
REQ-035 fflags_clr alone SHALL set fflags to 0.
REQ-036 fflags_clr together with a legal handshake SHALL set fflags to resp_flags.
REQ-037 Illegal responses SHALL never modify fflags.
REQ-038 req_valid asserted outside IDLE SHALL be ignored, with no latching.

Reset
REQ-039 With nrst=0 at a rising edge, the FSM SHALL go to IDLE and any in-flight op SHALL be discarded with no response.
REQ-040 Reset values: req_ready=1 (combinationally, from IDLE), resp_valid=0, resp_result=0, resp_flags=0, resp_tag=0, resp_illegal=0, fflags=0, busy=0, fpu_funct7=7'b1111111, fpu_fp1=0, fpu_fp2=0, fpu_frm=0.
REQ-041 Reset SHALL take priority over every handshake and over fflags_clr.

Verification
REQ-042 ADD 0x3F800000+0x40000000, rm 000, tag 3 -> resp_valid 5 cycles after accept; result 0x40400000, flags 0, tag 3, illegal 0.
REQ-043 MUL 0x40000000*0x40400000 with rm 111 and csr_frm 000 -> fpu_frm=000 throughout EXEC; result 0x40C00000.
REQ-044 ADD 0x7F800000+0xFF800000 -> resp_flags[4]=1; after the handshake fflags=5'b10000.
REQ-045 funct7 7'b0101010, or rm 3'b101 -> resp_valid on the next cycle, resp_illegal=1, fflags unchanged, fpu_funct7 stays 7'b1111111.
REQ-046 SUB 0x40400000-0x3F800000 with resp_ready low 3 cycles -> result 0x40000000 held stable; req_ready=0 until the handshake.
REQ-047 nrst=0 during EXEC cycle 2 -> the next cycle shows IDLE with all REQ-040 values; no response is produced.
